multi_timer: RTL and testbench

Parametrised N-channel programmable down-counter timer on the memory-mapped device bus; successor to the single-channel device timer.
Each channel has one-shot, auto-reload and square-wave modes, a sticky write-1-to-clear pending flag, and a per-channel mask.
A shared prescaler sets the count rate.
Sits beside the bridge as a device; its combined interrupt feeds the CP0 hardware-interrupt input.

---
 rtl/timer_pkg.sv | 20 ++
 rtl/multi_timer_if.sv | 10 +
 rtl/timer_channel.sv | 120 ++++++++++++
 rtl/multi_timer.sv | 71 +++++++
 tb/tb_multi_timer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared encodings for the multi-channel timer: modes, register offsets and channel FSM states.
package timer_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_SQUARE  = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    COUNTING = 2'd2
  } state_t;

endpackage

// File: rtl/multi_timer_if.sv
// Device-bus port bundle between the bridge (master) and the timer block (slave).
interface multi_timer_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport master (output Addr, output WE, output DataIn, input DataOut);
  modport slave  (input Addr, input WE, input DataIn, output DataOut);
endinterface

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, mode FSM and square-wave output.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_c,
  output logic        pending,
  output logic        im,
  output logic        tout
);

  state_t           state, state_nxt;
  logic             enable, enable_nxt;
  logic [1:0]       mode, mode_nxt;
  logic             im_nxt, pending_nxt, tout_nxt;
  logic [WIDTH-1:0] preset, preset_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic             wr_ctrl, wr_preset, wr_status;
  logic             oneshot, term;
  logic             unused_wdata;

  assign wr_ctrl      = we && (reg_sel == REG_CTRL);
  assign wr_preset    = we && (reg_sel == REG_PRESET);
  assign wr_status    = we && (reg_sel == REG_STATUS);
  assign unused_wdata = ^wdata;

  // Reserved mode behaves as one-shot
  assign oneshot = (mode == MODE_ONESHOT) || (mode == MODE_RSVD);
  // A count of 0 or 1 ends the period on the next tick
  assign term    = (state == COUNTING) && enable && tick && (count <= WIDTH'(1));

  // A bus write to CTRL overrides the one-shot self-disable
  assign enable_nxt = wr_ctrl ? wdata[0] : ((term && oneshot) ? 1'b0 : enable);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // IDLE looks at the post-write enable so the load lands one cycle after the CTRL write
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (enable_nxt) state_nxt = LOAD;
      LOAD:     state_nxt = COUNTING;
      COUNTING: begin
        if (!enable)              state_nxt = IDLE;
        else if (term && oneshot) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt   = count;
    tout_nxt    = tout;
    mode_nxt    = mode;
    im_nxt      = im;
    preset_nxt  = preset;
    pending_nxt = pending;

    if (state == LOAD) begin
      count_nxt = preset;
    end else if (state == COUNTING && enable && tick) begin
      if (!term)        count_nxt = count - WIDTH'(1);
      else if (oneshot) count_nxt = '0;
      else              count_nxt = preset;
      if (term && mode == MODE_SQUARE) tout_nxt = ~tout;
    end

    if (wr_ctrl) begin
      mode_nxt = wdata[2:1];
      im_nxt   = wdata[3];
    end
    if (wr_preset) preset_nxt = wdata[WIDTH-1:0];

    // Set beats a simultaneous write-1-to-clear
    if (term)                       pending_nxt = 1'b1;
    else if (wr_status && wdata[0]) pending_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable  <= 1'b0;
      mode    <= MODE_ONESHOT;
      im      <= 1'b0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
      tout    <= 1'b0;
    end else begin
      enable  <= enable_nxt;
      mode    <= mode_nxt;
      im      <= im_nxt;
      preset  <= preset_nxt;
      count   <= count_nxt;
      pending <= pending_nxt;
      tout    <= tout_nxt;
    end
  end

  always_comb begin
    rdata_c = '0;
    case (reg_sel)
      REG_CTRL:   rdata_c = {28'd0, im, mode, enable};
      REG_PRESET: rdata_c = 32'(preset);
      REG_COUNT:  rdata_c = 32'(count);
      REG_STATUS: rdata_c = {31'd0, pending};
      default:    rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/multi_timer.sv
// N-channel programmable down-counter timer on the device bus with shared prescaler and combined IRQ.
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned WIDTH    = 32,
  parameter logic [31:0] BASE     = 32'h0000_7F00,
  parameter int unsigned PRESCALE = 1
) (
  input  logic            clk,
  input  logic            reset,
  multi_timer_if.slave    bus,
  output logic            IRQ,
  output logic [N_CH-1:0] IRQ_VEC,
  output logic [N_CH-1:0] TOUT
);

  localparam int unsigned CHW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [31:0] SPAN = 32'(16 * N_CH);

  logic [PW-1:0]  pre_cnt;
  logic           tick;
  logic [31:0]    offset;
  logic           hit;
  logic [CHW-1:0] ch_idx;
  logic [31:0]    rdata [N_CH];
  logic [N_CH-1:0] pending, im;

  assign offset = bus.Addr - BASE;
  assign hit    = (bus.Addr >= BASE) && (offset < SPAN);
  assign ch_idx = offset[4 +: CHW];

  // Free-running prescaler; with PRESCALE=1 the compare is always true
  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic sel;
    assign sel = hit && (ch_idx == CHW'(i));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .we      (bus.WE && sel),
      .reg_sel (bus.Addr[3:2]),
      .wdata   (bus.DataIn),
      .rdata_c (rdata[i]),
      .pending (pending[i]),
      .im      (im[i]),
      .tout    (TOUT[i])
    );
  end

  always_comb begin
    bus.DataOut = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (hit && ch_idx == CHW'(i)) bus.DataOut = rdata[i];
    end
  end

  assign IRQ_VEC = pending & im;
  assign IRQ     = |IRQ_VEC;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: default instance, PRESCALE=3 instance and WIDTH=8 instance.
module tb_multi_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic clk = 1'b0;
  logic reset;
  always #50 clk = ~clk;

  multi_timer_if bus_a ();
  multi_timer_if bus_b ();
  multi_timer_if bus_c ();

  logic       irq_a;
  logic [1:0] irq_vec_a, tout_a;
  logic       unused_irq_b, unused_irq_c;
  logic [1:0] unused_vec_b, unused_tout_b, unused_vec_c, unused_tout_c;

  multi_timer dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .IRQ(irq_a), .IRQ_VEC(irq_vec_a), .TOUT(tout_a)
  );
  multi_timer #(.PRESCALE(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .IRQ(unused_irq_b), .IRQ_VEC(unused_vec_b),
    .TOUT(unused_tout_b)
  );
  multi_timer #(.WIDTH(8)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c), .IRQ(unused_irq_c), .IRQ_VEC(unused_vec_c),
    .TOUT(unused_tout_c)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned edges;

  // Rising edges since the last reset release, used to predict prescaler ticks
  always @(posedge clk or negedge reset) begin
    if (!reset) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic drive(input int d, input logic [31:0] a, input logic we, input logic [31:0] v);
    case (d)
      0:       begin bus_a.Addr = a; bus_a.WE = we; bus_a.DataIn = v; end
      1:       begin bus_b.Addr = a; bus_b.WE = we; bus_b.DataIn = v; end
      default: begin bus_c.Addr = a; bus_c.WE = we; bus_c.DataIn = v; end
    endcase
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
    drive(d, a, 1'b1, v);
    @(negedge clk);
    drive(d, a, 1'b0, 32'h0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input int d, input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    drive(d, a, 1'b0, 32'h0);
    #1;
    case (d)
      0:       v = bus_a.DataOut;
      1:       v = bus_b.DataOut;
      default: v = bus_c.DataOut;
    endcase
    chk(tag, v, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 32'h0, 1'b0, 32'h0);
    drive(1, 32'h0, 1'b0, 32'h0);
    drive(2, 32'h0, 1'b0, 32'h0);
    cyc(2);
    reset = 1'b1;

    // Reset state
    chk_rd(0, "rst_ctrl0", BASE + 32'h00, 32'h0);
    chk_rd(0, "rst_count1", BASE + 32'h18, 32'h0);
    chk_rd(0, "rst_status0", BASE + 32'h0C, 32'h0);
    chk("rst_irq", 32'(irq_a), 32'h0);
    chk("rst_tout", 32'(tout_a), 32'h0);

    // One-shot, ch0, PRESET=3, CTRL=1001
    wr(0, BASE + 32'h04, 32'd3);
    wr(0, BASE + 32'h00, 32'h9);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk_rd(0, "os_count", BASE + 32'h08, 32'(3 - i));
      chk("os_irq_early", 32'(irq_a), 32'h0);
    end
    cyc(1);
    chk_rd(0, "os_pending", BASE + 32'h0C, 32'h1);
    chk("os_irq", 32'(irq_a), 32'h1);
    chk("os_irq_vec", 32'(irq_vec_a), 32'h1);
    chk_rd(0, "os_count_end", BASE + 32'h08, 32'h0);
    chk_rd(0, "os_ctrl_end", BASE + 32'h00, 32'h8);
    wr(0, BASE + 32'h0C, 32'h1);
    chk("os_irq_clr", 32'(irq_a), 32'h0);
    chk_rd(0, "os_pending_clr", BASE + 32'h0C, 32'h0);

    // Auto-reload, ch1, PRESET=4, IM=0
    wr(0, BASE + 32'h14, 32'd4);
    wr(0, BASE + 32'h10, 32'h3);
    cyc(4);
    chk_rd(0, "ar_count_k4", BASE + 32'h18, 32'h1);
    chk_rd(0, "ar_pend_k4", BASE + 32'h1C, 32'h0);
    cyc(1);
    chk_rd(0, "ar_pend_k5", BASE + 32'h1C, 32'h1);
    chk_rd(0, "ar_reload_k5", BASE + 32'h18, 32'h4);
    chk("ar_irq_masked", 32'(irq_a), 32'h0);
    wr(0, BASE + 32'h1C, 32'h1);
    chk_rd(0, "ar_pend_clr", BASE + 32'h1C, 32'h0);
    chk_rd(0, "ar_count_k6", BASE + 32'h18, 32'h3);
    cyc(2);
    chk_rd(0, "ar_pend_k8", BASE + 32'h1C, 32'h0);
    cyc(1);
    chk_rd(0, "ar_pend_k9", BASE + 32'h1C, 32'h1);
    chk("ar_vec_masked", 32'(irq_vec_a), 32'h0);

    // Switch ch1 to square wave while counting: no restart, TOUT toggles per period
    wr(0, BASE + 32'h10, 32'h5);
    chk_rd(0, "sq_no_restart", BASE + 32'h18, 32'h3);
    cyc(2);
    chk("sq_tout_k12", 32'(tout_a), 32'h0);
    cyc(1);
    chk("sq_tout_k13", 32'(tout_a), 32'h2);
    cyc(3);
    chk("sq_tout_k16", 32'(tout_a), 32'h2);
    cyc(1);
    chk("sq_tout_k17", 32'(tout_a), 32'h0);
    cyc(4);
    chk("sq_tout_k21", 32'(tout_a), 32'h2);
    wr(0, BASE + 32'h10, 32'h0);
    cyc(10);
    chk("sq_tout_hold", 32'(tout_a), 32'h2);
    chk_rd(0, "sq_count_hold", BASE + 32'h18, 32'h3);

    // Collision: STATUS clear in the terminal cycle
    wr(0, BASE + 32'h04, 32'd2);
    wr(0, BASE + 32'h00, 32'h9);
    cyc(2);
    wr(0, BASE + 32'h0C, 32'h1);
    chk_rd(0, "col_set_wins", BASE + 32'h0C, 32'h1);
    wr(0, BASE + 32'h0C, 32'h1);
    chk_rd(0, "col_cleared", BASE + 32'h0C, 32'h0);

    // Collision: CTRL Enable=0 in the terminal cycle of an auto-reload
    wr(0, BASE + 32'h00, 32'hB);
    cyc(2);
    wr(0, BASE + 32'h00, 32'hA);
    chk_rd(0, "col_ctrl_wins", BASE + 32'h00, 32'hA);
    chk_rd(0, "col_pending", BASE + 32'h0C, 32'h1);
    chk_rd(0, "col_reload", BASE + 32'h08, 32'h2);
    chk("col_irq", 32'(irq_a), 32'h1);
    cyc(4);
    chk_rd(0, "col_idle_hold", BASE + 32'h08, 32'h2);
    wr(0, BASE + 32'h0C, 32'h1);

    // PRESET write mid-count only affects the next reload
    wr(0, BASE + 32'h04, 32'd3);
    wr(0, BASE + 32'h00, 32'h3);
    cyc(1);
    chk_rd(0, "pm_count_k1", BASE + 32'h08, 32'h3);
    wr(0, BASE + 32'h04, 32'd5);
    chk_rd(0, "pm_count_k2", BASE + 32'h08, 32'h2);
    cyc(1);
    chk_rd(0, "pm_count_k3", BASE + 32'h08, 32'h1);
    cyc(1);
    chk_rd(0, "pm_reload_new", BASE + 32'h08, 32'h5);
    wr(0, BASE + 32'h00, 32'h0);

    // Address decode and read-only COUNT
    chk_rd(0, "oob_hi", BASE + 32'h20, 32'h0);
    chk_rd(0, "oob_lo", BASE - 32'h4, 32'h0);
    wr(0, BASE + 32'h20, 32'h9);
    chk_rd(0, "oob_wr_ignored", BASE + 32'h00, 32'h0);
    wr(0, BASE + 32'h18, 32'hAB);
    chk_rd(0, "count_ro", BASE + 32'h18, 32'h3);

    // WIDTH=8 truncation / zero-extension, CTRL upper bits read 0
    wr(2, BASE + 32'h04, 32'h1FF);
    chk_rd(2, "w8_preset", BASE + 32'h04, 32'hFF);
    wr(2, BASE + 32'h00, 32'hFFFF_FFFE);
    chk_rd(2, "w8_ctrl", BASE + 32'h00, 32'hE);

    // PRESCALE=3, PRESET=2, one-shot; write edge aligned so the first tick is 3 after load
    wr(1, BASE + 32'h04, 32'd2);
    for (int g = 0; g < 3 && (edges % 3) != 1; g++) cyc(1);
    wr(1, BASE + 32'h00, 32'h9);
    for (int j = 1; j <= 7; j++) begin
      cyc(1);
      chk_rd(1, "ps_count", BASE + 32'h08, (j <= 3) ? 32'h2 : (j <= 6) ? 32'h1 : 32'h0);
      chk_rd(1, "ps_pending", BASE + 32'h0C, (j == 7) ? 32'h1 : 32'h0);
    end

    // Async reset mid-count
    wr(0, BASE + 32'h04, 32'd100);
    wr(0, BASE + 32'h00, 32'h9);
    wr(0, BASE + 32'h14, 32'd1);
    wr(0, BASE + 32'h10, 32'hD);
    cyc(3);
    chk("ar_pre_tout", 32'(tout_a), 32'h2);
    chk("ar_pre_irq", 32'(irq_a), 32'h1);
    #20 reset = 1'b0;
    #1;
    chk("rst_async_irq", 32'(irq_a), 32'h0);
    chk("rst_async_vec", 32'(irq_vec_a), 32'h0);
    chk("rst_async_tout", 32'(tout_a), 32'h0);
    chk_rd(0, "rst_async_ctrl1", BASE + 32'h10, 32'h0);
    chk_rd(0, "rst_async_count0", BASE + 32'h08, 32'h0);
    chk_rd(0, "rst_async_preset0", BASE + 32'h04, 32'h0);
    chk_rd(0, "rst_async_status1", BASE + 32'h1C, 32'h0);
    cyc(2);
    reset = 1'b1;
    cyc(5);
    chk_rd(0, "post_rst_count0", BASE + 32'h08, 32'h0);
    chk_rd(0, "post_rst_ctrl0", BASE + 32'h00, 32'h0);
    chk("post_rst_irq", 32'(irq_a), 32'h0);
    chk("post_rst_tout", 32'(tout_a), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
